// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Ports: clk, rst (async active-low), hazard/exception inputs -> stall_C/flush_C, exc_redirect_o, busy_o, lost_cycles_o.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH  = 6,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_use_i,
  input  logic                  branch_taken_i,
  input  logic                  md_start_i,
  input  logic [CNT_WIDTH-1:0]  md_cycles_i,
  input  logic                  exc_valid_i,
  output logic [3:0]            stall_C,
  output logic [3:0]            flush_C,
  output logic                  exc_redirect_o,
  output logic                  busy_o,
  output logic [PERF_WIDTH-1:0] lost_cycles_o
);

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    EXC_RECOVER
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           stall_d, flush_d;
  logic                 redir_d;
  logic                 md_multi;
  logic                 any_c;

  assign md_multi = md_start_i &&
                    (md_cycles_i >= CNT_WIDTH'(2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 4'b0000;
    flush_d = 4'b0000;
    redir_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (exc_valid_i) begin
          flush_d = 4'b1111;
          redir_d = 1'b1;
          state_d = EXC_RECOVER;
        end else if (md_multi) begin
          // start cycle is the first stall; N-2 remain
          stall_d = 4'b1111;
          cnt_d   = md_cycles_i - CNT_WIDTH'(2);
          state_d = MD_BUSY;
        end else if (branch_taken_i) begin
          flush_d = 4'b0010;
        end else if (load_use_i) begin
          stall_d = 4'b0011;
          flush_d = 4'b0100;
        end
      end
      MD_BUSY: begin
        if (exc_valid_i) begin
          flush_d = 4'b1111;
          redir_d = 1'b1;
          cnt_d   = '0;
          state_d = EXC_RECOVER;
        end else if (cnt_q != '0) begin
          stall_d = 4'b1111;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
        end else begin
          state_d = RUN;
        end
      end
      EXC_RECOVER: begin
        if (exc_valid_i) begin
          flush_d = 4'b1111;
          redir_d = 1'b1;
          state_d = EXC_RECOVER;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // inputs may be live while in reset; keep outputs quiet
  assign stall_C        = rst ? stall_d : 4'b0000;
  assign flush_C        = rst ? flush_d : 4'b0000;
  assign exc_redirect_o = rst ? redir_d : 1'b0;
  assign busy_o         = rst && (state_q != RUN);
  assign any_c          = (|stall_C) | (|flush_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lost_cycles_o <= '0;
    end else if (any_c && (lost_cycles_o != '1)) begin
      lost_cycles_o <= lost_cycles_o + PERF_WIDTH'(1);
    end
  end

endmodule
